swizzle_c2d_sched: RTL

- Controller that shares one CRAM-to-DRAM swizzle unit between NUM_REQ compute-RAM requesters.
- Arbitrates round-robin and reads the winner's source words at one word per cycle.
- Drives the swizzle's valid/last/start-address inputs, then waits for the swizzle to drain before reporting completion.
- Sits between the compute-RAM array and the swizzle_cram_to_dram instance.

---
 rtl/swizzle_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/swizzle_c2d_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/swizzle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | swizzle_pkg : shared state encoding and drain timing for the c2d scheduler |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package swizzle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } sched_state_e;

  localparam int COUNT_TO_SWITCH_BUFFERS = 40;
  localparam int DEFAULT_DRAIN_CYCLES    = COUNT_TO_SWITCH_BUFFERS + 2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr                |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]     req,
  input  logic [LOG_NUM_REQ-1:0] ptr,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [LOG_NUM_REQ-1:0] idx,
  output logic                   any
);

  logic [LOG_NUM_REQ-1:0] cand;

  // NUM_REQ is a power of two, so the rotated index wraps by truncation.
  always_comb begin
    gnt  = '0;
    idx  = ptr;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + LOG_NUM_REQ'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/swizzle_c2d_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | swizzle_c2d_sched : shares one CRAM-to-DRAM swizzle among NUM_REQ requesters|
// | Optional perf counters enabled by macro SWZ_SCHED_PERF_EN                  |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module swizzle_c2d_sched
  import swizzle_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOG_NUM_REQ  = 2,
  parameter int AWIDTH       = 9,
  parameter int LEN_W        = 10,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*AWIDTH-1:0] req_dst_addr,
  input  logic [NUM_REQ*AWIDTH-1:0] req_src_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [LOG_NUM_REQ-1:0]    src_sel,
  output logic                      src_rd_en,
  output logic [AWIDTH-1:0]         src_rd_addr,
  input  logic                      swz_stall,
  output logic                      swz_data_valid,
  output logic                      swz_data_last,
  output logic [AWIDTH-1:0]         swz_addr_start,
`ifdef SWZ_SCHED_PERF_EN
  output logic [15:0]               perf_stall_cnt,
  output logic [15:0]               perf_xfer_cnt,
`endif
  output logic                      busy
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  sched_state_e           state, state_nx;
  logic [1:0]             rst_sync;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [LOG_NUM_REQ-1:0] arb_idx;
  logic                   arb_any;
  logic [LOG_NUM_REQ-1:0] rr_ptr;
  logic [AWIDTH-1:0]      rd_ptr;
  logic [LEN_W-1:0]       remaining;
  logic [DCW-1:0]         drain_cnt;
  logic [AWIDTH-1:0]      win_dst;
  logic [AWIDTH-1:0]      win_src;
  logic [LEN_W-1:0]       win_len;
  logic                   issue;

  // Reset asserts asynchronously and releases two clocks after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  rr_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LOG_NUM_REQ (LOG_NUM_REQ)
  ) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign win_dst = req_dst_addr[int'(arb_idx)*AWIDTH +: AWIDTH];
  assign win_src = req_src_addr[int'(arb_idx)*AWIDTH +: AWIDTH];
  assign win_len = req_len[int'(arb_idx)*LEN_W +: LEN_W];

  assign issue       = (state == STREAM) && !swz_stall && (remaining != '0);
  assign src_rd_en   = issue;
  assign src_rd_addr = rd_ptr;
  assign done        = (state == DONE) ? gnt : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = ARB;
      ARB: begin
        if (!arb_any)            state_nx = IDLE;
        else if (win_len == '0)  state_nx = DONE;
        else                     state_nx = STREAM;
      end
      STREAM:  if (issue && remaining == LEN_W'(1)) state_nx = DRAIN;
      DRAIN:   if (drain_cnt <= DCW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt            <= '0;
      src_sel        <= '0;
      swz_addr_start <= '0;
      rd_ptr         <= '0;
      remaining      <= '0;
      rr_ptr         <= '0;
      drain_cnt      <= '0;
      swz_data_valid <= 1'b0;
      swz_data_last  <= 1'b0;
    end else begin
      // The CRAM read returns one cycle after issue, so valid/last trail by one.
      swz_data_valid <= issue;
      swz_data_last  <= issue && (remaining == LEN_W'(1));

      if (state == ARB && arb_any) begin
        src_sel        <= arb_idx;
        swz_addr_start <= win_dst;
        rd_ptr         <= win_src;
        remaining      <= win_len;
        gnt            <= arb_gnt;
        rr_ptr         <= arb_idx + LOG_NUM_REQ'(1);
      end

      if (issue) begin
        rd_ptr    <= rd_ptr + AWIDTH'(1);
        remaining <= remaining - LEN_W'(1);
      end

      if (state == STREAM && state_nx == DRAIN) drain_cnt <= DCW'(DRAIN_CYCLES);
      else if (state == DRAIN)                  drain_cnt <= drain_cnt - DCW'(1);

      if (state == DONE) gnt <= '0;
    end
  end

`ifdef SWZ_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_xfer_cnt  <= '0;
    end else begin
      if (state == STREAM && swz_stall && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (state != DONE && state_nx == DONE && perf_xfer_cnt != 16'hFFFF)
        perf_xfer_cnt <= perf_xfer_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
